// File: rtl/ctrl_pkg.sv
// Control-word field layout, instruction code constants and the control-word -> {opcode, aluop} encoder.
// Shared with the control decoder so both sides agree on the same eight encodings.
package ctrl_pkg;

  typedef struct packed {
    logic [1:0] jmp_sel;
    logic       write_register;
    logic       mem_write;
    logic [1:0] reg_write;
    logic [1:0] vcsub;
    logic [2:0] alu_op;
    logic [1:0] selector_opb;
    logic       selector_rs2;
    logic [1:0] branch_sel;
  } ctrl_word_t;

  typedef struct packed {
    logic       legal;
    logic [4:0] opcode;
    logic [2:0] aluop;
  } enc_t;

  typedef enum logic {ST_RUN, ST_TRAP} enc_state_t;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;

  localparam ctrl_word_t CW_ADD  = 16'h2400;
  localparam ctrl_word_t CW_ADDI = 16'h2408;
  localparam ctrl_word_t CW_SUB  = 16'h2420;
  localparam ctrl_word_t CW_SUBI = 16'h2428;
  localparam ctrl_word_t CW_MUL  = 16'h2440;
  localparam ctrl_word_t CW_SLL  = 16'h2480;
  localparam ctrl_word_t CW_AND  = 16'h24A0;
  localparam ctrl_word_t CW_SRL  = 16'h24C0;

  // Exact-match lookup: any bit pattern outside the eight words is illegal.
  function automatic enc_t encode(input ctrl_word_t cw);
    enc_t e;
    e = '0;
    case (cw)
      CW_ADD:  e = '{1'b1, OP_RTYPE, ALU_ADD};
      CW_ADDI: e = '{1'b1, OP_ADDI,  ALU_ADD};
      CW_SUB:  e = '{1'b1, OP_RTYPE, ALU_SUB};
      CW_SUBI: e = '{1'b1, OP_SUBI,  ALU_SUB};
      CW_MUL:  e = '{1'b1, OP_RTYPE, ALU_MUL};
      CW_SLL:  e = '{1'b1, OP_RTYPE, ALU_SLL};
      CW_AND:  e = '{1'b1, OP_RTYPE, ALU_AND};
      CW_SRL:  e = '{1'b1, OP_RTYPE, ALU_SRL};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Generic synchronous FIFO; head entry is visible combinationally, zero when empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/instr_encoder.sv
// Re-encodes control words into {opcode, aluop}, buffers them in a FIFO and counts illegal words.
// Build option ILLEGAL_TRAP_EN: an illegal word stops intake until trap_clear.
module instr_encoder
  import ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cw_valid,
  input  logic [15:0]     cw_data,
  output logic            cw_ready,
  output logic            ins_valid,
  output logic [4:0]      ins_opcode,
  output logic [2:0]      ins_aluop,
  input  logic            ins_ready,
  output logic            err_pulse,
  output logic [ERRW-1:0] err_count,
  input  logic            trap_clear,
  output logic            trapped
);

  enc_t            enc;
  logic            run;
  logic            full;
  logic            empty;
  logic            accept;
  logic            illegal;
  logic [7:0]      head;
  logic            err_pulse_reg;
  logic [ERRW-1:0] err_count_reg;

  assign enc      = encode(ctrl_word_t'(cw_data));
  // Intake never looks at ins_ready, so a full FIFO stalls even while popping.
  assign cw_ready = !full && run;
  assign accept   = cw_valid && cw_ready;
  assign illegal  = accept && !enc.legal;

  instr_enc_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && enc.legal),
    .wr_data ({enc.opcode, enc.aluop}),
    .rd_en   (ins_ready),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign ins_valid  = !empty;
  assign ins_opcode = head[7:3];
  assign ins_aluop  = head[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse_reg <= 1'b0;
      err_count_reg <= '0;
    end else begin
      err_pulse_reg <= illegal;
      if (illegal && err_count_reg != '1) err_count_reg <= err_count_reg + 1'b1;
    end
  end

  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;

`ifdef ILLEGAL_TRAP_EN
  enc_state_t state_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
    end else begin
      case (state_reg)
        ST_RUN:  if (illegal) state_reg <= ST_TRAP;
        ST_TRAP: if (trap_clear) state_reg <= ST_RUN;
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  assign run     = (state_reg == ST_RUN);
  assign trapped = (state_reg == ST_TRAP);
`else
  logic unused_trap_clear;
  assign unused_trap_clear = trap_clear;
  assign run     = 1'b1;
  assign trapped = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder (DEPTH=4, ERRW=8); trap checks follow ILLEGAL_TRAP_EN.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cw_valid;
  logic [15:0] cw_data;
  logic        cw_ready;
  logic        ins_valid;
  logic [4:0]  ins_opcode;
  logic [2:0]  ins_aluop;
  logic        ins_ready;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic        trap_clear;
  logic        trapped;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(4), .ERRW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cw_valid   (cw_valid),
    .cw_data    (cw_data),
    .cw_ready   (cw_ready),
    .ins_valid  (ins_valid),
    .ins_opcode (ins_opcode),
    .ins_aluop  (ins_aluop),
    .ins_ready  (ins_ready),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .trap_clear (trap_clear),
    .trapped    (trapped)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] words [5] = '{16'h2408, 16'h2428, 16'h2440, 16'h2480, 16'h24A0};
  logic [7:0]  codes [5] = '{8'h40, 8'h49, 8'h02, 8'h04, 8'h05};

  initial begin
    rst = 1'b1; cw_valid = 1'b0; cw_data = '0; ins_ready = 1'b0; trap_clear = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_ins_valid", ins_valid, 0);
    check("rst_code", {ins_opcode, ins_aluop}, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_count", err_count, 0);
    check("rst_trapped", trapped, 0);
    check("rst_cw_ready", cw_ready, 1);

    // Streaming: ADD, SUB, SRL with consumer always ready.
    ins_ready = 1'b1;
    cw_valid = 1'b1; cw_data = 16'h2400;
    step();
    check("s_valid0", ins_valid, 1);
    check("s_add", {ins_opcode, ins_aluop}, 8'h00);
    cw_data = 16'h2420;
    step();
    check("s_sub", {ins_opcode, ins_aluop}, 8'h01);
    cw_data = 16'h24C0;
    step();
    cw_valid = 1'b0;
    check("s_srl", {ins_opcode, ins_aluop}, 8'h06);
    step();
    check("s_empty", ins_valid, 0);

    // Fill to DEPTH with consumer stalled; fifth word must be held off.
    ins_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cw_valid = 1'b1; cw_data = words[i];
      check($sformatf("f_ready%0d", i), cw_ready, 1);
      step();
    end
    cw_data = words[4];
    check("f_full_ready", cw_ready, 0);
    step();
    check("f_stall_ready", cw_ready, 0);
    check("f_hold_head", {ins_opcode, ins_aluop}, codes[0]);
    // Full and popping in the same cycle: pop only, push lands one edge later.
    ins_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("d_head%0d", i), {ins_opcode, ins_aluop}, codes[i]);
      if (i == 0) check("d_ready_full", cw_ready, 0);
      if (i == 1) check("d_ready_after_pop", cw_ready, 1);
      step();
      if (i == 1) cw_valid = 1'b0;
    end
    check("d_drained", ins_valid, 0);

    // Illegal word: dropped, one-cycle pulse, counted.
    cw_valid = 1'b1; cw_data = 16'h1234;
    step();
    cw_valid = 1'b0;
    check("i_pulse", err_pulse, 1);
    check("i_count", err_count, 1);
    check("i_no_write", ins_valid, 0);
`ifdef ILLEGAL_TRAP_EN
    check("i_trapped", trapped, 1);
    check("i_trap_ready", cw_ready, 0);
    trap_clear = 1'b1; step(); trap_clear = 1'b0;
`else
    check("i_not_trapped", trapped, 0);
`endif
    step();
    check("i_pulse_low", err_pulse, 0);
    check("i_count_hold", err_count, 1);

    // 299 more illegal words: count saturates at 255.
    for (int n = 2; n <= 300; n++) begin
      cw_valid = 1'b1; cw_data = 16'h1234 + 16'(n);
      step();
      cw_valid = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      trap_clear = 1'b1; step(); trap_clear = 1'b0;
`endif
      if (n == 254) check("sat_254", err_count, 254);
    end
    step();
    check("sat_255", err_count, 255);
    check("sat_no_write", ins_valid, 0);

`ifdef ILLEGAL_TRAP_EN
    // Trap holds off the following legal word until cleared.
    ins_ready = 1'b0;
    cw_valid = 1'b1; cw_data = 16'hFFFF;
    step();
    cw_data = 16'h2408;
    check("t_trapped", trapped, 1);
    check("t_ready", cw_ready, 0);
    step();
    check("t_held", ins_valid, 0);
    trap_clear = 1'b1;
    step();
    trap_clear = 1'b0;
    check("t_cleared", trapped, 0);
    check("t_ready_back", cw_ready, 1);
    step();
    cw_valid = 1'b0;
    check("t_addi", {ins_opcode, ins_aluop}, 8'h40);
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0;
`endif

    // Reset with three entries queued discards them.
    ins_ready = 1'b0;
    cw_valid = 1'b1;
    cw_data = 16'h2400; step();
    cw_data = 16'h2420; step();
    cw_data = 16'h2440; step();
    cw_valid = 1'b0;
    check("r_queued", ins_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("r_valid", ins_valid, 0);
    check("r_err_count", err_count, 0);
    check("r_cw_ready", cw_ready, 1);
    cw_valid = 1'b1; cw_data = 16'h2480;
    step();
    cw_valid = 1'b0;
    check("r_fresh_head", {ins_opcode, ins_aluop}, 8'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
